// File: rtl/ref_block_fetch.sv
// Reference block fetcher: reads an N x N block from the frame store with
// edge-clamped coordinates and streams it out in raster order through a 2-entry FIFO.
module ref_block_fetch #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int N          = 8,
  parameter int NUM_FRAMES = 4,
  parameter int ADDR_W     = $clog2(NUM_FRAMES*WIDTH*HEIGHT)
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [$clog2(NUM_FRAMES)-1:0] req_frame_i,
  input  logic signed [11:0]            req_x_i,
  input  logic signed [11:0]            req_y_i,
  output logic                          mem_rd_en_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  input  logic [7:0]                    mem_rdata_i,
  output logic                          pix_valid_o,
  input  logic                          pix_ready_i,
  output logic [7:0]                    pix_data_o,
  output logic                          pix_last_o,
  output logic                          busy_o
);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e             state_q;
  logic [FW-1:0]      frame_q;
  logic signed [11:0] x_q, y_q;
  logic [CW-1:0]      col_q, row_q;
  logic               inflight_q, inflight_last_q;
  logic [1:0][7:0]    fifo_data_q;
  logic [1:0]         fifo_last_q;
  logic               rptr_q, wptr_q;
  logic [1:0]         cnt_q;

  logic               pop, rd_en, blk_last;
  logic signed [12:0] sx, sy;
  logic [XW-1:0]      cx;
  logic [YW-1:0]      cy;

  assign pix_valid_o = (cnt_q != 2'd0);
  assign pix_data_o  = fifo_data_q[rptr_q];
  assign pix_last_o  = pix_valid_o & fifo_last_q[rptr_q];
  assign pop         = pix_valid_o & pix_ready_i;
  assign blk_last    = (col_q == CW'(N-1)) && (row_q == CW'(N-1));
  // Reserve a slot for every read in flight; a pop this cycle frees one.
  assign rd_en       = (state_q == FETCH) &&
                       ((3'(cnt_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  assign mem_rd_en_o = rd_en;
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);

  // Counters and request only move on an issued read or an accept, so the
  // address naturally holds its last value between reads.
  always_comb begin
    sx = 13'(x_q) + 13'(col_q);
    sy = 13'(y_q) + 13'(row_q);
    if (sx[12])                      cx = '0;
    else if (sx > 13'(WIDTH-1))      cx = XW'(WIDTH-1);
    else                             cx = sx[XW-1:0];
    if (sy[12])                      cy = '0;
    else if (sy > 13'(HEIGHT-1))     cy = YW'(HEIGHT-1);
    else                             cy = sy[YW-1:0];
    mem_addr_o = ADDR_W'(frame_q) * ADDR_W'(WIDTH*HEIGHT)
               + ADDR_W'(cy) * ADDR_W'(WIDTH) + ADDR_W'(cx);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      frame_q         <= '0;
      x_q             <= '0;
      y_q             <= '0;
      col_q           <= '0;
      row_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_data_q     <= '0;
      fifo_last_q     <= '0;
      rptr_q          <= 1'b0;
      wptr_q          <= 1'b0;
      cnt_q           <= '0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en & blk_last;
      if (inflight_q) begin
        fifo_data_q[wptr_q] <= mem_rdata_i;
        fifo_last_q[wptr_q] <= inflight_last_q;
        wptr_q              <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(inflight_q) - 2'(pop);

      case (state_q)
        IDLE: if (req_valid_i) begin
          frame_q <= (int'(req_frame_i) >= NUM_FRAMES) ? FW'(NUM_FRAMES-1) : req_frame_i;
          x_q     <= req_x_i;
          y_q     <= req_y_i;
          col_q   <= '0;
          row_q   <= '0;
          state_q <= FETCH;
        end
        FETCH: if (rd_en) begin
          if (blk_last) state_q <= DRAIN;
          else if (col_q == CW'(N-1)) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else col_q <= col_q + 1'b1;
        end
        DRAIN: if (pop && pix_last_o) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ref_block_fetch.sv
// Directed bench for ref_block_fetch: memory returns mem[a] = a[7:0] one cycle
// after each read; cycle numbers are counted from the request-accept edge.
module tb_ref_block_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [1:0]  req_frame = '0;
  logic signed [11:0] req_x = '0, req_y = '0;
  logic        mem_rd_en;
  logic [20:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic        pix_valid, pix_ready = 1'b0, pix_last, busy;
  logic [7:0]  pix_data;

  int n_cmp = 0, n_err = 0;
  logic [7:0] got[$], ref_q[$];
  int lasts[$], addrs[$];
  int first_cyc, last_cyc, ready_cyc, max_out;

  ref_block_fetch dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_frame_i(req_frame), .req_x_i(req_x), .req_y_i(req_y),
    .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .pix_valid_o(pix_valid), .pix_ready_i(pix_ready), .pix_data_o(pix_data),
    .pix_last_o(pix_last), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ea(int fr, int x, int y, int r, int c);
    int px, py;
    px = x + c; py = y + r;
    if (px < 0) px = 0;
    if (px > 639) px = 639;
    if (py < 0) py = 0;
    if (py > 479) py = 479;
    return fr*307200 + py*640 + px;
  endfunction

  task automatic set_req(input int fr, input int x, input int y);
    req_frame = 2'(fr); req_x = 12'(x); req_y = 12'(y); req_valid = 1'b1;
  endtask

  task automatic chk_block(input string tag, input int fr, input int x, input int y);
    chk({tag, "_npix"}, got.size(), 64);
    chk({tag, "_nlast"}, lasts.size(), 1);
    if (lasts.size() > 0) chk({tag, "_lastidx"}, lasts[0], 63);
    for (int i = 0; i < 64 && i < got.size(); i++)
      chk($sformatf("%s_pix%0d", tag, i), got[i], ea(fr, x, y, i/8, i%8) & 255);
    for (int i = 0; i < 64 && i < addrs.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), addrs[i], ea(fr, x, y, i/8, i%8));
  endtask

  // Entered mid-cycle with the request on the bus; returns mid-cycle once
  // req_ready is back (or right after pixel abort_at handshakes).
  task automatic run_blk(input bit rnd, input int abort_at, input bit chain,
                         input int fr2, input int x2, input int y2);
    int c, outst;
    bit holding;
    logic [7:0] hd;
    logic hl;
    got.delete(); lasts.delete(); addrs.delete();
    first_cyc = -1; last_cyc = -1; ready_cyc = -1; max_out = 0;
    outst = 0; holding = 0; hd = '0; hl = 1'b0;
    chk("req_ready_at_accept", req_ready, 1);
    @(posedge clk); #1; c = 1;
    if (chain) set_req(fr2, x2, y2); else req_valid = 1'b0;
    while (c < 3000) begin
      pix_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
      #1;
      if (holding) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", pix_data, hd);
        chk("hold_last", pix_last, hl);
      end
      if (mem_rd_en) begin addrs.push_back(int'(mem_addr)); outst++; end
      if (pix_valid && first_cyc < 0) first_cyc = c;
      if (pix_valid && pix_ready) begin
        got.push_back(pix_data);
        if (pix_last) lasts.push_back(got.size() - 1);
        last_cyc = c; outst--;
      end
      holding = pix_valid && !pix_ready; hd = pix_data; hl = pix_last;
      if (outst > max_out) max_out = outst;
      if (abort_at >= 0 && got.size() == abort_at + 1) break;
      if (req_ready && lasts.size() > 0) begin ready_cyc = c; break; end
      @(posedge clk); #1; c++;
    end
    chk("blk_within_budget", (c < 3000), 1);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_last", pix_last, 0);
    chk("rst_busy", busy, 0);

    // interior fetch
    set_req(1, 16, 8);
    run_blk(0, -1, 0, 0, 0, 0);
    chk("int_first_addr", addrs.size() > 0 ? addrs[0] : -1, 312336);
    chk("int_first_cyc", first_cyc, 3);
    chk("int_last_cyc", last_cyc, 66);
    chk("int_ready_cyc", ready_cyc, 67);
    chk("int_max_out", max_out <= 2, 1);
    chk_block("int", 1, 16, 8);
    ref_q = got;

    // corner clamp
    set_req(2, -3, -2);
    run_blk(0, -1, 0, 0, 0, 0);
    chk("cor_first_addr", addrs.size() > 0 ? addrs[0] : -1, 614400);
    chk("cor_addr19", addrs.size() > 19 ? addrs[19] : -1, 614400);
    chk("cor_addr4", addrs.size() > 4 ? addrs[4] : -1, 614401);
    chk("cor_addr24", addrs.size() > 24 ? addrs[24] : -1, 614400 + 640);
    chk_block("cor", 2, -3, -2);

    // far-edge clamp
    set_req(3, 636, 476);
    run_blk(0, -1, 0, 0, 0, 0);
    chk("far_first_addr", addrs.size() > 0 ? addrs[0] : -1, 1226876);
    chk("far_last_addr", addrs.size() > 63 ? addrs[63] : -1, 1228799);
    chk("far_addr7", addrs.size() > 7 ? addrs[7] : -1, 1226879);
    begin
      int mx = 0;
      foreach (addrs[i]) if (addrs[i] > mx) mx = addrs[i];
      chk("far_max_addr_in_frame", mx <= 1228799, 1);
    end
    chk_block("far", 3, 636, 476);

    // backpressure: same stream as the interior run
    set_req(1, 16, 8);
    run_blk(1, -1, 0, 0, 0, 0);
    chk("bp_npix", got.size(), ref_q.size());
    for (int i = 0; i < 64 && i < got.size(); i++)
      chk($sformatf("bp_pix%0d", i), got[i], ref_q[i]);
    chk("bp_max_out", max_out <= 2, 1);
    chk("bp_lastidx", lasts.size() == 1 && lasts[0] == 63, 1);

    // back-to-back: second request waits on the bus
    set_req(0, 100, 50);
    run_blk(0, -1, 1, 1, -5, 470);
    chk("b2b_ready_cyc", ready_cyc, 67);
    chk("b2b_valid_held", req_valid, 1);
    chk_block("b2b_a", 0, 100, 50);
    run_blk(0, -1, 0, 0, 0, 0);
    chk("b2b_second_first_cyc", first_cyc, 3);
    chk_block("b2b_b", 1, -5, 470);

    // reset mid-block
    set_req(0, 0, 0);
    run_blk(0, 20, 0, 0, 0, 0);
    chk("mid_npix_before_rst", got.size(), 21);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_rd_en", mem_rd_en, 0);
    chk("mid_addr", mem_addr, 0);
    chk("mid_pix_valid", pix_valid, 0);
    chk("mid_pix_data", pix_data, 0);
    chk("mid_pix_last", pix_last, 0);
    chk("mid_busy", busy, 0);
    @(posedge clk); #2;
    chk("mid_stale_dropped", pix_valid, 0);
    set_req(2, 200, 100);
    run_blk(0, -1, 0, 0, 0, 0);
    chk("post_first_cyc", first_cyc, 3);
    chk("post_ready_cyc", ready_cyc, 67);
    chk_block("post", 2, 200, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ref_block_fetch.md
# ref_block_fetch

Reads N×N reference blocks out of the reference frame store that the loop-filter frame buffer manager fills, for motion compensation. Takes a block request (frame slot plus top-left integer-pel position, which may lie outside the frame) and issues single-pixel reads on a one-cycle-latency memory port. Clamps coordinates to the frame edge, which replicates border pixels. Streams the block out in raster order on a valid/ready interface with full backpressure support.

## Interface
- WIDTH, 640, frame width in pixels
- HEIGHT, 480, frame height in pixels
- N, 8, block edge length (N×N pixels per request)
- NUM_FRAMES, 4, reference frame slots in the store
- ADDR_W, $clog2(NUM_FRAMES*WIDTH*HEIGHT), memory address width
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  block request valid
- req_ready  out  1  block fetcher idle, can accept a request
- req_frame  in  $clog2(NUM_FRAMES)  reference frame slot
- req_x  in  12 signed  top-left column, may be negative or ≥ WIDTH
- req_y  in  12 signed  top-left row, may be negative or ≥ HEIGHT
- mem_rd_en  out  1  read strobe
- mem_addr  out  ADDR_W  read address = frame*WIDTH*HEIGHT + cy*WIDTH + cx
- mem_rdata  in  8  read data, valid exactly one cycle after mem_rd_en
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  8  pixel value
- pix_last  out  1  marks pixel (N-1, N-1) of the block
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- **IDLE**
  - req_ready=1.
  - On req_valid: latch req_frame/req_x/req_y, clear row/col counters, go to FETCH.
- **FETCH**
  - Issue reads in raster order: col 0..N-1 within row, row 0..N-1.
  - cx = clamp(req_x+col, 0, WIDTH-1); cy = clamp(req_y+row, 0, HEIGHT-1).
  - Compute sums at 13 bits signed before clamping; no wrap is permitted.
  - After issuing read (N-1, N-1), go to DRAIN.
- **DRAIN**
  - No reads issued.
  - Go to IDLE in the cycle after the pix_last handshake (pix_valid & pix_ready & pix_last).
- **Output buffer**
  - 2-entry FIFO; mem_rdata is written the cycle after mem_rd_en.
  - inflight = 1 when mem_rd_en was high in the previous cycle.
- **Read-issue rule:** mem_rd_en=1 in FETCH iff occupancy + inflight − pop < 2, where pop = pix_valid & pix_ready this cycle. The FIFO never overflows, and with pix_ready held high sustained throughput is 1 pixel/cycle.
- **pix_valid / pix_last**
  - pix_valid = FIFO non-empty.
  - pix_data = FIFO head.
  - pix_last is carried through the FIFO alongside each pixel.
- req_frame ≥ NUM_FRAMES: clamped to NUM_FRAMES-1.
- Requests are accepted only in IDLE; req_valid in other states is ignored (held upstream).
- **Reset mid-operation**
  - State returns to IDLE; counters, FIFO and inflight are cleared.
  - Any mem_rdata returning the cycle after reset is discarded.

## Timing
- **Reset values:**
  - req_ready=1
  - mem_rd_en=0, mem_addr=0
  - pix_valid=0, pix_data=0, pix_last=0
  - busy=0
- Request accepted at edge E0 (req_valid & req_ready).
- **Latency from E0:**
  - First mem_rd_en in cycle 1.
  - Data in cycle 2, written to the FIFO at E2.
  - pix_valid first high in cycle 3.
- With pix_ready constantly high:
  - Pixels are presented in cycles 3..N*N+2, with pix_last in cycle N*N+2.
  - req_ready is high again in cycle N*N+3.
- **pix_valid hold rule:** once high, pix_valid stays high, and pix_data/pix_last stay stable, until the handshake.
- **pix_ready low:**
  - At most 2 pixels are buffered and reads stall.
  - Reads resume in the same cycle pix_ready returns high; the stall inserts no bubbles beyond the stall itself.
- mem_addr is valid only when mem_rd_en=1; otherwise it holds its last value.

## Test plan
- **Interior fetch.** Memory model mem[a]=a[7:0]. Request frame 1, x=16, y=8, N=8, pix_ready=1.
  - 64 pixels in cycles 3..66.
  - First addr = 307200+8*640+16 = 312336.
  - pix_last only on pixel 63.
  - req_ready high in cycle 67.
- **Corner clamp.** Request x=-3, y=-2.
  - Rows 0–2 all read cy=0.
  - Cols 0–3 all read cx=0.
  - Pixel (0,0) through (2,3) equal mem[frame base].
- **Far-edge clamp.** Request x=636, y=476.
  - Every column ≥4 reads cx=639; every row ≥4 reads cy=479.
  - No address exceeds frame base + 307199.
- **Backpressure.** Random pix_ready at 30% high.
  - Output sequence is identical to the pix_ready=1 run.
  - FIFO occupancy never exceeds 2.
  - pix_data stays stable while pix_valid & !pix_ready.
- **Back-to-back requests.** req_valid held high with a second request queued.
  - The second request is accepted exactly in the cycle req_ready rises (N*N+3).
  - Its first pixel appears 3 cycles later.
- **Reset mid-block.** Assert reset for 1 cycle after pixel 20.
  - All outputs return to reset values the next cycle.
  - The stale mem_rdata is not emitted.
  - A new request afterwards produces a full correct 64-pixel block.
